// File: rtl/axi_lite_responder_if.sv
// AXI4-Lite bus bundle between the initiator (master) and the responder (slave).
interface axi_lite_responder_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_responder.sv
// AXI4-Lite responder backed by a word-addressed memory with OKAY/SLVERR decode.
// Define AXI_LITE_SEQ_CHECK_EN to build the sequential-write-address checker (o_seq_err).
module axi_lite_responder #(
  parameter int                        AXI_ADDR_WIDTH = 64,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        MEM_DEPTH      = 16,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                  clk,
  input  logic                  arst,
  axi_lite_responder_if.slave   axi,
  output logic                  o_seq_err
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int SB     = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] STRIDE = AXI_ADDR_WIDTH'(STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_DATA } r_state_e;

  function automatic logic addr_in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> SB) < AXI_ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> SB);
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  w_state_e                  w_state_q, w_state_d;
  logic                      aw_held_q, aw_held_d;
  logic                      w_held_q, w_held_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic [1:0]                bresp_q, bresp_d;

  logic                      awready, wready, aw_fire, w_fire, commit, cm_ok;
  logic [AXI_ADDR_WIDTH-1:0] cm_addr;
  logic [AXI_DATA_WIDTH-1:0] cm_data;
  logic [STRB_W-1:0]         cm_strb;

  // Ready flags come straight from state so no input reaches an output combinationally.
  assign awready = (w_state_q == W_IDLE) && !aw_held_q;
  assign wready  = (w_state_q == W_IDLE) && !w_held_q;
  assign aw_fire = axi.awvalid && awready;
  assign w_fire  = axi.wvalid && wready;

  assign cm_addr = aw_held_q ? awaddr_q : axi.awaddr;
  assign cm_data = w_held_q ? wdata_q : axi.wdata;
  assign cm_strb = w_held_q ? wstrb_q : axi.wstrb;
  assign cm_ok   = addr_in_range(cm_addr);

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awaddr_d  = axi.awaddr;
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = axi.wdata;
          wstrb_d  = axi.wstrb;
        end
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
          commit    = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = cm_ok ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (commit && cm_ok) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (cm_strb[b]) mem_q[word_idx(cm_addr)][8*b +: 8] <= cm_data[8*b +: 8];
      end
    end
  end

  r_state_e                  r_state_q, r_state_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      arready, ar_fire;

  assign arready = (r_state_q == R_IDLE);
  assign ar_fire = axi.arvalid && arready;

  // mem_q is sampled before this edge's write lands, so a same-cycle read sees the old word.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          if (addr_in_range(axi.araddr)) begin
            rdata_d = mem_q[word_idx(axi.araddr)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (axi.rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign axi.awready = awready;
  assign axi.wready  = wready;
  assign axi.bvalid  = (w_state_q == W_RESP);
  assign axi.bresp   = bresp_q;
  assign axi.arready = arready;
  assign axi.rvalid  = (r_state_q == R_DATA);
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

`ifdef AXI_LITE_SEQ_CHECK_EN
  logic [AXI_ADDR_WIDTH-1:0] exp_addr_q;
  logic                      seq_err_q;

  // The expectation always advances from the committed address, so one stray write flags once.
  always_ff @(posedge clk) begin
    if (arst) begin
      exp_addr_q <= BASE_ADDR;
      seq_err_q  <= 1'b0;
    end else if (commit) begin
      exp_addr_q <= cm_addr + STRIDE;
      if (cm_addr != exp_addr_q) seq_err_q <= 1'b1;
    end
  end

  assign o_seq_err = seq_err_q;
`else
  assign o_seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_responder.sv
// Scoreboard bench for axi_lite_responder: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them on each handshake.
module tb_axi_lite_responder;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic seq_err;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

`ifdef AXI_LITE_SEQ_CHECK_EN
  localparam logic SEQ_EN = 1'b1;
`else
  localparam logic SEQ_EN = 1'b0;
`endif

  axi_lite_responder_if #(.ADDR_W(64), .DATA_W(32)) axi ();

  axi_lite_responder #(
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(32),
    .MEM_DEPTH(16),
    .BASE_ADDR(64'd0)
  ) dut (
    .clk(clk),
    .arst(arst),
    .axi(axi),
    .o_seq_err(seq_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Monitor: every B/R handshake consumes the oldest expected response.
  initial begin
    logic [1:0]  eb;
    logic [33:0] er;
    forever begin
      @(negedge clk);
      if (axi.bvalid === 1'b1 && axi.bready === 1'b1) begin
        if (exp_b.size() == 0) begin
          fail_now("b_unexpected");
        end else begin
          eb = exp_b.pop_front();
          check("bresp", 64'(axi.bresp), 64'(eb));
        end
      end
      if (axi.rvalid === 1'b1 && axi.rready === 1'b1) begin
        if (exp_r.size() == 0) begin
          fail_now("r_unexpected");
        end else begin
          er = exp_r.pop_front();
          check("rdata", 64'(axi.rdata), 64'(er[31:0]));
          check("rresp", 64'(axi.rresp), 64'(er[33:32]));
        end
      end
    end
  end

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W. bdly: cycles bready stays low.
  task automatic do_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input int bdly, input logic [1:0] er);
    bit aw_done, w_done, b_done, aw_hs, w_hs, b_hs, raise;
    int hs_cyc, bseen, held;
    logic [1:0] bhold;
    aw_done = 0; w_done = 0; b_done = 0; hs_cyc = 0; bseen = -1; held = 0; bhold = '0;
    exp_b.push_back(er);
    axi.awaddr = a;
    axi.wdata  = d;
    axi.wstrb  = s;
    axi.bready = (bdly == 0);
    for (int n = 0; n < 80 && !b_done; n++) begin
      if (!aw_done) axi.awvalid = (n >= lead);
      if (!w_done)  axi.wvalid  = (n >= -lead);
      raise = 0;
      @(negedge clk);
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      b_hs  = axi.bvalid && axi.bready;
      if (w_done && !aw_done) check("wready_held_low", 64'(axi.wready), 64'h0);
      if (aw_done && !w_done) check("awready_held_low", 64'(axi.awready), 64'h0);
      if (axi.bvalid && bseen < 0) begin
        bseen = cyc;
        bhold = axi.bresp;
        check("b_latency", 64'(cyc), 64'(hs_cyc));
      end
      if (axi.bvalid && !axi.bready) begin
        check("b_hold_bresp", 64'(axi.bresp), 64'(bhold));
        check("b_hold_awready", 64'(axi.awready), 64'h0);
        held++;
        if (held >= bdly) raise = 1;
      end
      @(posedge clk);
      #1;
      if (aw_hs) begin
        aw_done = 1;
        axi.awvalid = 1'b0;
        if (cyc > hs_cyc) hs_cyc = cyc;
      end
      if (w_hs) begin
        w_done = 1;
        axi.wvalid = 1'b0;
        if (cyc > hs_cyc) hs_cyc = cyc;
      end
      if (b_hs) b_done = 1;
      if (raise) axi.bready = 1'b1;
    end
    if (!b_done) fail_now("write_timeout");
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b1;
  endtask

  task automatic do_read(input logic [63:0] a, input logic [31:0] ed, input logic [1:0] er);
    bit ar_done, r_done, ar_hs, r_hs;
    int hs_cyc;
    ar_done = 0; r_done = 0; hs_cyc = -1;
    exp_r.push_back({er, ed});
    axi.araddr  = a;
    axi.arvalid = 1'b1;
    axi.rready  = 1'b1;
    for (int n = 0; n < 40 && !r_done; n++) begin
      @(negedge clk);
      ar_hs = axi.arvalid && axi.arready;
      r_hs  = axi.rvalid && axi.rready;
      if (ar_done && cyc == hs_cyc) check("r_latency", 64'(axi.rvalid), 64'h1);
      if (ar_done) check("arready_in_rdata", 64'(axi.arready), 64'h0);
      @(posedge clk);
      #1;
      if (ar_hs) begin
        ar_done = 1;
        axi.arvalid = 1'b0;
        hs_cyc = cyc;
      end
      if (r_hs) r_done = 1;
    end
    if (!r_done) fail_now("read_timeout");
    axi.arvalid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b1; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", 64'(axi.awready), 64'h1);
    check("rst_wready",  64'(axi.wready),  64'h1);
    check("rst_arready", 64'(axi.arready), 64'h1);
    check("rst_bvalid",  64'(axi.bvalid),  64'h0);
    check("rst_rvalid",  64'(axi.rvalid),  64'h0);
    check("rst_bresp",   64'(axi.bresp),   64'h0);
    check("rst_rresp",   64'(axi.rresp),   64'h0);
    check("rst_rdata",   64'(axi.rdata),   64'h0);
    check("rst_seq_err", 64'(seq_err),     64'h0);
    arst = 1'b0;

    do_write(64'h0, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00);
    do_read(64'h0, 32'hDEADBEEF, 2'b00);
    do_read(64'h3, 32'hDEADBEEF, 2'b00);

    do_write(64'h4, 32'h12345678, 4'hF, 3, 0, 2'b00);
    do_read(64'h4, 32'h12345678, 2'b00);

    do_write(64'h8, 32'h11223344, 4'hF, 0, 0, 2'b00);
    do_write(64'h8, 32'hAABBCCDD, 4'h5, 0, 0, 2'b00);
    do_read(64'h8, 32'h11BB33DD, 2'b00);

    do_read(64'h3C, 32'h0, 2'b00);
    do_write(64'h3C, 32'hCAFEF00D, 4'hF, -2, 0, 2'b00);
    do_read(64'h3C, 32'hCAFEF00D, 2'b00);

    do_write(64'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b10);
    do_read(64'h40, 32'h0, 2'b10);
    do_read(64'h1_0000_0000, 32'h0, 2'b10);
    do_read(64'h0, 32'hDEADBEEF, 2'b00);
    do_read(64'h4, 32'h12345678, 2'b00);
    do_read(64'h8, 32'h11BB33DD, 2'b00);
    do_read(64'h3C, 32'hCAFEF00D, 2'b00);

    do_write(64'hC, 32'h55AA55AA, 4'hF, 0, 5, 2'b00);
    do_read(64'hC, 32'h55AA55AA, 2'b00);

    fork
      do_write(64'hC, 32'h01020304, 4'hF, 0, 0, 2'b00);
      do_read(64'hC, 32'h55AA55AA, 2'b00);
    join
    do_read(64'hC, 32'h01020304, 2'b00);

    fork
      do_write(64'h10, 32'h0BADCAFE, 4'hF, 0, 0, 2'b00);
      begin
        @(posedge clk);
        #1;
        do_read(64'h10, 32'h0BADCAFE, 2'b00);
      end
    join

    axi.awaddr = 64'h0; axi.wdata = 32'h77; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
    @(posedge clk);
    #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_bvalid", 64'(axi.bvalid), 64'h1);
    @(posedge clk);
    #1;
    arst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_bvalid",  64'(axi.bvalid),  64'h0);
    check("mid_rst_awready", 64'(axi.awready), 64'h1);
    check("mid_rst_wready",  64'(axi.wready),  64'h1);
    arst = 1'b0;
    axi.bready = 1'b1;
    do_read(64'h0, 32'h0, 2'b00);
    do_read(64'hC, 32'h0, 2'b00);

    do_write(64'h0, 32'h1, 4'hF, 0, 0, 2'b00);
    check("seq_ok_0", 64'(seq_err), 64'h0);
    do_write(64'h4, 32'h2, 4'hF, 0, 0, 2'b00);
    check("seq_ok_4", 64'(seq_err), 64'h0);
    do_write(64'h8, 32'h3, 4'hF, 0, 0, 2'b00);
    check("seq_ok_8", 64'(seq_err), 64'h0);
    do_write(64'h10, 32'h4, 4'hF, 0, 0, 2'b00);
    check("seq_err_set", 64'(seq_err), 64'(SEQ_EN));
    do_write(64'h14, 32'h5, 4'hF, 0, 0, 2'b00);
    check("seq_err_sticky_14", 64'(seq_err), 64'(SEQ_EN));
    do_write(64'h18, 32'h6, 4'hF, 0, 0, 2'b00);
    check("seq_err_sticky_18", 64'(seq_err), 64'(SEQ_EN));
    @(posedge clk);
    #1;
    arst = 1'b1;
    @(posedge clk);
    #1;
    arst = 1'b0;
    check("seq_err_cleared", 64'(seq_err), 64'h0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_b.size() + exp_r.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_responder.md
# axi_lite_responder

AXI4-Lite responder (slave) terminating the single-beat, address-incrementing transfers issued by the team's AXI4-Lite initiator. It backs the address space with an internal word-addressed memory, returns OKAY/SLVERR responses, and optionally checks that writes arrive at strictly sequential word addresses. It sits at the memory-side end of the burst path, used as a bus-side scratch store and as a verification target for the initiator.

## Interface
- AXI_ADDR_WIDTH, 64, address bus width.
- AXI_DATA_WIDTH, 32, data bus width; the word stride is AXI_DATA_WIDTH/8 bytes (4 at default).
- MEM_DEPTH, 16, number of memory words; power of two, at least 2.
- BASE_ADDR, 64'd0, byte address of word 0; word-aligned.

- clk  in  1  clock; all logic is rising-edge.
- arst  in  1  reset; synchronous, active-high.
- awaddr  in  AXI_ADDR_WIDTH  write address.
- awvalid / awready  in / out  1  write-address handshake.
- wdata  in  AXI_DATA_WIDTH  write data.
- wstrb  in  AXI_DATA_WIDTH/8  byte enables.
- wvalid / wready  in / out  1  write-data handshake.
- bresp  out  2  write response.
- bvalid / bready  out / in  1  write-response handshake.
- araddr  in  AXI_ADDR_WIDTH  read address.
- arvalid / arready  in / out  1  read-address handshake.
- rdata  out  AXI_DATA_WIDTH  read data.
- rresp  out  2  read response.
- rvalid / rready  out / in  1  read-data handshake.
- o_seq_err  out  1  sticky flag for a non-sequential write address.

## Operation
- Decode: idx = (addr - BASE_ADDR) / stride, with byte-offset bits ignored. An access is in range when BASE_ADDR <= addr and idx < MEM_DEPTH; otherwise it is an error.
- Write FSM states:
  - W_IDLE: awready = 1 until AW is captured; wready = 1 until W is captured. AW and W are captured independently, in either order or in the same cycle.
  - Once both are held, the write commits and the FSM goes to W_RESP.
  - Commit: an in-range write updates each byte lane whose wstrb bit is 1 and returns bresp = 2'b00 (OKAY). An out-of-range write leaves memory unchanged and returns bresp = 2'b10 (SLVERR).
  - W_RESP: bvalid = 1 with bresp stable, awready = wready = 0. On bvalid && bready the FSM returns to W_IDLE.
- Read FSM states:
  - R_IDLE: arready = 1. On arvalid && arready, rdata/rresp are registered and the FSM goes to R_DATA.
  - Read result: an in-range read returns mem[idx] with rresp = 2'b00. An out-of-range read returns rdata = 0 with rresp = 2'b10.
  - R_DATA: rvalid = 1, arready = 0, rdata/rresp held stable. On rready the FSM returns to R_IDLE.
- Read and write to the same word in the same cycle: the read returns the pre-write value.
- Reset: memory is cleared to 0 and both FSMs go to IDLE. Output values in reset: awready = wready = arready = 1; bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0; o_seq_err = 0.
- Reset mid-transaction discards any captured AW/W/AR and any pending response.

## Timing
- Write: the B channel is valid the cycle after the later of the AW and W handshakes. The memory update is visible to a read accepted in that same following cycle.
- Read: AR handshake at edge N gives rvalid and rdata at N+1.
- Throughput: at most one write per 2 cycles and one read per 2 cycles (with bready/rready tied high). The read and write channels are fully concurrent.
- All outputs are registered or decoded directly from state; there is no combinational path from any input to any output.

## Configuration
- AXI_LITE_SEQ_CHECK_EN defined:
  - An expected-address register resets to BASE_ADDR.
  - At every write commit, if awaddr != expected, o_seq_err is set. It stays set until arst.
  - At every commit, expected <= awaddr + stride, independent of the comparison result.
  - bresp is unaffected by the check.
- AXI_LITE_SEQ_CHECK_EN undefined: o_seq_err is tied to 0 and no checker logic is built.

## Test plan
- AW and W in the same cycle to 0x0 with data 0xDEADBEEF, wstrb 0xF → bvalid next cycle with bresp 00; a following read of 0x0 returns 0xDEADBEEF with rresp 00.
- W presented 3 cycles before AW at 0x4 → wready drops after the W handshake; bvalid 1 cycle after the AW handshake; memory word 1 updated.
- Write 0x11223344 to 0x8, then write 0xAABBCCDD with wstrb 0x5 → reading 0x8 returns 0x11BB33DD.
- Write to BASE_ADDR + 4*MEM_DEPTH → bresp 10 and no memory word changes; read of the same address → rdata 0, rresp 10.
- bready held low for 5 cycles → bvalid and bresp stable throughout; awready stays 0 until the B handshake. Assert arst during W_RESP → bvalid 0 and awready 1 the next cycle.
- With AXI_LITE_SEQ_CHECK_EN: writes at 0x0, 0x4, 0x8 → o_seq_err stays 0. A following write at 0x10 → o_seq_err = 1, and it stays 1 through further sequential writes until arst.
